// File: rtl/matrix_loader_pkg.sv
// Shared types and constants for the nibble-serial matrix loader.
package matrix_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LD_A,
        S_LD_B,
        S_DONE,
        S_ERR
    } state_t;

    // Position of each dimension inside the header (arrival order).
    localparam int HDR_R1 = 0;
    localparam int HDR_C1 = 1;
    localparam int HDR_R2 = 2;
    localparam int HDR_C2 = 3;

    // Nibbles per element.
    function automatic int calc_npe(input int elem_w, input int nib_w);
        return elem_w / nib_w;
    endfunction

    // Elements must pack into a whole number of nibbles.
    function automatic bit elem_w_ok(input int elem_w, input int nib_w);
        return (nib_w > 0) && (elem_w >= nib_w) && ((elem_w % nib_w) == 0);
    endfunction

endpackage

// File: rtl/nibble_packer.sv
// Assembles NPE nibbles (most significant first) into one element and
// pulses elem_valid combinationally on the nibble that completes it, so the
// caller can store elem_out on that same edge.
module nibble_packer
    import matrix_loader_pkg::*;
#(
    parameter int NIB_W  = 4,
    parameter int ELEM_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [NIB_W-1:0]  nib_in,
    output logic [ELEM_W-1:0] elem_out,
    output logic              elem_valid
);

    localparam int NPE   = calc_npe(ELEM_W, NIB_W);
    localparam int CNT_W = (NPE > 1) ? $clog2(NPE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPE - 1);

    logic [ELEM_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;

    // Shifting the older nibbles up keeps the first-arrived nibble in the MSBs.
    assign elem_out   = (shift_q << NIB_W) | ELEM_W'(nib_in);
    assign elem_valid = shift_en && (cnt_q == LAST);

    // Shift register and nibble counter; clear discards a partial element.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!RST_N) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= elem_out;
            cnt_q   <= elem_valid ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Nibble-serial loader: parses a four-field dimension header, packs and
// stores matrix A then matrix B row-major, and serves a registered
// random-access read port until the downstream engine acks.
module matrix_stream_loader
    import matrix_loader_pkg::*;
#(
    parameter int NIB_W  = 4,
    parameter int ELEM_W = 32,
    parameter int MAX_R  = 4,
    parameter int MAX_C  = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NIB_W-1:0]    in_data,
    input  logic                in_hdr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                rd_sel,
    input  logic [NIB_W-1:0]    rd_row,
    input  logic [NIB_W-1:0]    rd_col,
    output logic [ELEM_W-1:0]   rd_data,
    output logic [4*NIB_W-1:0]  dims,
    output logic                load_done,
    output logic                load_err,
    input  logic                ack
);

    if (!elem_w_ok(ELEM_W, NIB_W)) begin : g_bad_elem_w
        $error("ELEM_W must be a non-zero multiple of NIB_W");
    end

    localparam int RI_W = (MAX_R > 1) ? $clog2(MAX_R) : 1;
    localparam int CI_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [NIB_W:0] MAX_R_W = (NIB_W+1)'(MAX_R);
    localparam logic [NIB_W:0] MAX_C_W = (NIB_W+1)'(MAX_C);

    state_t             state_q, state_d;
    logic [NIB_W-1:0]   dim_q [4];
    logic [NIB_W-1:0]   hdr_idx_q;
    logic [NIB_W-1:0]   row_q, col_q;
    logic               load_done_q, load_err_q;
    logic [ELEM_W-1:0]  rd_data_q;
    logic [ELEM_W-1:0]  mem [2][MAX_R][MAX_C];

    logic               hdr_acc, dat_acc, loading, sel_b;
    logic [NIB_W-1:0]   cur_r, cur_c;
    logic               row_last, col_last, last_elem, hdr_ok, rd_in_range;
    logic [NIB_W-1:0]   rd_lim_r, rd_lim_c;
    logic [ELEM_W-1:0]  elem;
    logic               elem_valid;

    function automatic logic dim_in_range(input logic [NIB_W-1:0] d,
                                          input logic [NIB_W:0]   max_d);
        return (d != '0) && ({1'b0, d} <= max_d);
    endfunction

    assign hdr_acc = in_valid && in_ready && in_hdr;
    assign dat_acc = in_valid && in_ready && !in_hdr;
    assign loading = (state_q == S_LD_A) || (state_q == S_LD_B);
    assign sel_b   = (state_q == S_LD_B);
    assign cur_r   = sel_b ? dim_q[HDR_R2] : dim_q[HDR_R1];
    assign cur_c   = sel_b ? dim_q[HDR_C2] : dim_q[HDR_C1];

    assign row_last  = (row_q == cur_r - 1'b1);
    assign col_last  = (col_q == cur_c - 1'b1);
    assign last_elem = elem_valid && row_last && col_last;

    // The incoming beat is C2 when the header completes, so it is checked live.
    assign hdr_ok = dim_in_range(dim_q[HDR_R1], MAX_R_W) &&
                    dim_in_range(dim_q[HDR_C1], MAX_C_W) &&
                    dim_in_range(dim_q[HDR_R2], MAX_R_W) &&
                    dim_in_range(in_data,       MAX_C_W) &&
                    (dim_q[HDR_C1] == dim_q[HDR_R2]);

    nibble_packer #(
        .NIB_W  (NIB_W),
        .ELEM_W (ELEM_W)
    ) u_packer (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clear      (!loading || hdr_acc),
        .shift_en   (loading && dat_acc),
        .nib_in     (in_data),
        .elem_out   (elem),
        .elem_valid (elem_valid)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake decode.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d  = state_q;
        in_ready = 1'b1;
        case (state_q)
            S_IDLE: if (hdr_acc) state_d = S_HDR;
            S_HDR: begin
                if (hdr_acc) begin
                    if (hdr_idx_q == NIB_W'(HDR_C2)) state_d = hdr_ok ? S_LD_A : S_ERR;
                end else if (dat_acc) begin
                    state_d = S_ERR;
                end
            end
            S_LD_A: begin
                if (hdr_acc)        state_d = S_HDR;
                else if (last_elem) state_d = S_LD_B;
            end
            S_LD_B: begin
                if (hdr_acc)        state_d = S_HDR;
                else if (last_elem) state_d = S_DONE;
            end
            S_DONE: begin
                in_ready = 1'b0;
                if (ack) state_d = S_IDLE;
            end
            S_ERR:   if (hdr_acc) state_d = S_HDR;
            default: state_d = S_IDLE;
        endcase
    end

    // Header capture: any header beat outside HDR restarts at R1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) dim_q[i] <= '0;
            hdr_idx_q <= '0;
        end else if (hdr_acc) begin
            if (state_q == S_HDR) begin
                dim_q[hdr_idx_q[1:0]] <= in_data;
                hdr_idx_q             <= hdr_idx_q + 1'b1;
            end else begin
                dim_q[HDR_R1] <= in_data;
                hdr_idx_q     <= NIB_W'(1);
            end
        end
    end

    // Row-major element position; wraps to 0,0 after the last element of A.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_q <= '0;
            col_q <= '0;
        end else if (!loading || hdr_acc) begin
            row_q <= '0;
            col_q <= '0;
        end else if (elem_valid) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Status flags follow the state being entered, so they register with it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            load_done_q <= (state_d == S_DONE);
            load_err_q  <= (state_d == S_ERR);
        end
    end

    // Element storage write on the completing nibble.
    always_ff @(posedge CLK) begin
        // NOTE: the arrays carry no reset; reads are gated by the loaded
        // dimensions, so stale contents are never visible.
        if (elem_valid) mem[sel_b][row_q[RI_W-1:0]][col_q[CI_W-1:0]] <= elem;
    end

    assign rd_lim_r    = rd_sel ? dim_q[HDR_R2] : dim_q[HDR_R1];
    assign rd_lim_c    = rd_sel ? dim_q[HDR_C2] : dim_q[HDR_C1];
    assign rd_in_range = (rd_row < rd_lim_r) && ({1'b0, rd_row} < MAX_R_W) &&
                         (rd_col < rd_lim_c) && ({1'b0, rd_col} < MAX_C_W);

    // Registered read port; out-of-range indices return zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)           rd_data_q <= '0;
        else if (rd_in_range) rd_data_q <= mem[rd_sel][rd_row[RI_W-1:0]][rd_col[CI_W-1:0]];
        else                  rd_data_q <= '0;
    end

    assign rd_data   = rd_data_q;
    assign dims      = {dim_q[HDR_R1], dim_q[HDR_C1], dim_q[HDR_R2], dim_q[HDR_C2]};
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader (ELEM_W=8, 4x4 maximum).
module tb_matrix_stream_loader;

    localparam int NIB_W  = 4;
    localparam int ELEM_W = 8;
    localparam int MAX_R  = 4;
    localparam int MAX_C  = 4;
    localparam int NPE    = ELEM_W / NIB_W;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [NIB_W-1:0]  in_data = '0;
    logic              in_hdr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              rd_sel = 1'b0;
    logic [NIB_W-1:0]  rd_row = '0;
    logic [NIB_W-1:0]  rd_col = '0;
    logic [ELEM_W-1:0] rd_data;
    logic [4*NIB_W-1:0] dims;
    logic              load_done;
    logic              load_err;
    logic              ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: intended matrix contents and loaded dimensions.
    logic [ELEM_W-1:0] ma [MAX_R][MAX_C];
    logic [ELEM_W-1:0] mb [MAX_R][MAX_C];
    int m_r1, m_c1, m_r2, m_c2;

    typedef struct {
        logic [3:0] r1, c1, r2, c2;
        logic       exp_err;
    } hvec_t;

    matrix_stream_loader #(
        .NIB_W (NIB_W), .ELEM_W (ELEM_W), .MAX_R (MAX_R), .MAX_C (MAX_C)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_data   (in_data),
        .in_hdr    (in_hdr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd_sel    (rd_sel),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_data   (rd_data),
        .dims      (dims),
        .load_done (load_done),
        .load_err  (load_err),
        .ack       (ack)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One beat; called at a negedge, returns at the negedge after transfer.
    task automatic beat(input logic h, input logic [NIB_W-1:0] d, input int gap);
        int n;
        repeat (gap) @(negedge CLK);
        in_valid = 1'b1; in_hdr = h; in_data = d;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge CLK); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL beat_timeout: in_ready 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input int r1, c1, r2, c2, input int gmax);
        beat(1'b1, NIB_W'(r1), $urandom_range(0, gmax));
        beat(1'b1, NIB_W'(c1), $urandom_range(0, gmax));
        beat(1'b1, NIB_W'(r2), $urandom_range(0, gmax));
        beat(1'b1, NIB_W'(c2), $urandom_range(0, gmax));
    endtask

    task automatic send_elem(input logic [ELEM_W-1:0] v, input int gmax);
        logic [ELEM_W-1:0] t;
        t = v;
        for (int i = 0; i < NPE; i++) begin
            beat(1'b0, t[ELEM_W-1 -: NIB_W], $urandom_range(0, gmax));
            t = t << NIB_W;
        end
    endtask

    task automatic send_model(input int gmax);
        for (int r = 0; r < m_r1; r++) for (int c = 0; c < m_c1; c++) send_elem(ma[r][c], gmax);
        for (int r = 0; r < m_r2; r++) for (int c = 0; c < m_c2; c++) send_elem(mb[r][c], gmax);
    endtask

    task automatic rd_check(input string name, input bit sel, input int r, c, input logic [ELEM_W-1:0] exp);
        rd_sel = sel; rd_row = NIB_W'(r); rd_col = NIB_W'(c);
        @(negedge CLK);
        check(name, rd_data, exp);
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(negedge CLK);
        ack = 1'b0;
    endtask

    function automatic bit hdr_bad(input int r1, c1, r2, c2);
        return r1 < 1 || r1 > MAX_R || c1 < 1 || c1 > MAX_C ||
               r2 < 1 || r2 > MAX_R || c2 < 1 || c2 > MAX_C || c1 != r2;
    endfunction

    function automatic logic [ELEM_W-1:0] exp_rd(input bit sel, input int r, c);
        if (!sel) return (r < m_r1 && c < m_c1) ? ma[r][c] : '0;
        return (r < m_r2 && c < m_c2) ? mb[r][c] : '0;
    endfunction

    task automatic set_model(input int r1, c1, r2, c2);
        m_r1 = r1; m_c1 = c1; m_r2 = r2; m_c2 = c2;
        for (int r = 0; r < MAX_R; r++)
            for (int c = 0; c < MAX_C; c++) begin
                ma[r][c] = ELEM_W'($urandom);
                mb[r][c] = ELEM_W'($urandom);
            end
    endtask

    hvec_t hv [10];

    initial begin
        hv[0] = '{4'd1, 4'd1, 4'd1, 4'd1, 1'b0};
        hv[1] = '{4'd4, 4'd4, 4'd4, 4'd4, 1'b0};
        hv[2] = '{4'd0, 4'd1, 4'd1, 4'd1, 1'b1};
        hv[3] = '{4'd1, 4'd0, 4'd0, 4'd1, 1'b1};
        hv[4] = '{4'd4, 4'd5, 4'd5, 4'd1, 1'b1};
        hv[5] = '{4'd2, 4'd3, 4'd3, 4'd4, 1'b0};
        hv[6] = '{4'd3, 4'd2, 4'd3, 4'd2, 1'b1};
        hv[7] = '{4'd4, 4'd1, 4'd1, 4'd4, 1'b0};
        hv[8] = '{4'd5, 4'd5, 4'd5, 4'd5, 1'b1};
        hv[9] = '{4'd1, 4'd4, 4'd4, 4'd0, 1'b1};

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_ready", in_ready, 1);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        check("rst_dims", dims, 0);
        check("rst_rd", rd_data, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // 1: 2x3 * 3x2 load, two nibbles per element
        send_hdr(2, 3, 3, 2, 0);
        for (int i = 0; i < 6; i++) send_elem(ELEM_W'(8'h01 + i), 0);
        check("t1_done_early", load_done, 0);
        for (int i = 0; i < 6; i++) send_elem(ELEM_W'(8'h10 + i), 0);
        check("t1_done", load_done, 1);
        check("t1_dims", dims, 16'h2332);
        check("t1_ready_low", in_ready, 0);
        rd_check("t1_a00", 1'b0, 0, 0, 8'h01);
        rd_sel = 1'b0; rd_row = 4'd1; rd_col = 4'd2;
        #1 check("t1_rd_latency", rd_data, 8'h01);
        @(negedge CLK);
        check("t1_a12", rd_data, 8'h06);
        rd_check("t1_b21", 1'b1, 2, 1, 8'h15);
        rd_check("t1_b_oob_col", 1'b1, 0, 2, 8'h00);
        ack_pulse();
        check("t1_ack_done", load_done, 0);
        check("t1_ack_ready", in_ready, 1);

        // 2: C1 != R2, then recovery
        send_hdr(2, 3, 2, 2, 0);
        check("t2_err", load_err, 1);
        beat(1'b0, 4'h7, 0);
        beat(1'b0, 4'h8, 1);
        check("t2_err_sticky", load_err, 1);
        check("t2_ready", in_ready, 1);
        beat(1'b1, 4'd1, 0);
        check("t2_err_clr", load_err, 0);
        beat(1'b1, 4'd1, 0); beat(1'b1, 4'd1, 0); beat(1'b1, 4'd1, 0);
        send_elem(8'hA5, 0);
        send_elem(8'h3C, 0);
        check("t2_done", load_done, 1);
        rd_check("t2_a00", 1'b0, 0, 0, 8'hA5);
        rd_check("t2_b00", 1'b1, 0, 0, 8'h3C);
        ack_pulse();

        // 3: oversize rows, then data inside the header
        send_hdr(5, 1, 1, 1, 0);
        check("t3_err_max", load_err, 1);
        beat(1'b1, 4'd2, 0);
        check("t3_err_clr", load_err, 0);
        beat(1'b1, 4'd2, 0);
        beat(1'b0, 4'd9, 0);
        check("t3_err_data_in_hdr", load_err, 1);

        // Header validation table; each entry's first beat restarts the parse.
        foreach (hv[i]) begin
            send_hdr(hv[i].r1, hv[i].c1, hv[i].r2, hv[i].c2, 1);
            check($sformatf("tbl%0d_err", i), load_err, hv[i].exp_err);
            check($sformatf("tbl%0d_dims", i), dims, {hv[i].r1, hv[i].c1, hv[i].r2, hv[i].c2});
        end

        // 4: header beat after three elements of A restarts the load
        send_hdr(2, 2, 2, 2, 0);
        send_elem(8'hEE, 0); send_elem(8'hEE, 0); send_elem(8'hEE, 0);
        beat(1'b1, 4'd1, 0);
        check("t4_restart_done", load_done, 0);
        check("t4_restart_err", load_err, 0);
        check("t4_restart_r1", dims[15:12], 1);
        beat(1'b1, 4'd2, 0); beat(1'b1, 4'd2, 0); beat(1'b1, 4'd1, 0);
        send_elem(8'h41, 0); send_elem(8'h42, 0);
        send_elem(8'h51, 0); send_elem(8'h52, 0);
        check("t4_done", load_done, 1);
        check("t4_dims", dims, 16'h1221);
        rd_check("t4_a01", 1'b0, 0, 1, 8'h42);
        rd_check("t4_b10", 1'b1, 1, 0, 8'h52);
        rd_check("t4_b_oob_row", 1'b1, 2, 0, 8'h00);

        // 5: stalled header beat in DONE
        in_valid = 1'b1; in_hdr = 1'b1; in_data = 4'd3;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t5_stall%0d", i), in_ready, 0);
            @(negedge CLK);
        end
        check("t5_held_dims", dims, 16'h1221);
        ack = 1'b1;
        @(negedge CLK);
        ack = 1'b0;
        check("t5_ready_after_ack", in_ready, 1);
        check("t5_done_clr", load_done, 0);
        @(negedge CLK);
        in_valid = 1'b0;
        check("t5_r1_taken", dims[15:12], 3);
        beat(1'b1, 4'd1, 0); beat(1'b1, 4'd1, 0); beat(1'b1, 4'd2, 0);
        check("t5_hdr_dims", dims, 16'h3112);
        check("t5_hdr_ok", load_err, 0);

        // 6: asynchronous reset in the middle of B
        send_elem(8'h11, 0); send_elem(8'h22, 0); send_elem(8'h33, 0);
        rd_check("t6_pre_rd", 1'b0, 2, 0, 8'h33);
        send_elem(8'h99, 0);
        beat(1'b0, 4'h5, 0);
        #2 RST_N = 1'b0;
        #1;
        check("t6_rst_done", load_done, 0);
        check("t6_rst_err", load_err, 0);
        check("t6_rst_ready", in_ready, 1);
        check("t6_rst_rd", rd_data, 0);
        check("t6_rst_dims", dims, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        set_model(2, 2, 2, 2);
        send_hdr(2, 2, 2, 2, 0);
        send_model(0);
        check("t6_done", load_done, 1);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                rd_check($sformatf("t6_a%0d%0d", r, c), 1'b0, r, c, ma[r][c]);
                rd_check($sformatf("t6_b%0d%0d", r, c), 1'b1, r, c, mb[r][c]);
            end
        rd_check("t6_a33_oob", 1'b0, 3, 3, 8'h00);
        ack_pulse();

        // Randomized loads against the reference model
        for (int it = 0; it < 25; it++) begin
            int r1, c1, r2, c2;
            bit bad;
            if ($urandom_range(0, 3) == 0) begin
                r1 = $urandom_range(0, 6); c1 = $urandom_range(0, 6);
                r2 = $urandom_range(0, 6); c2 = $urandom_range(0, 6);
            end else begin
                r1 = $urandom_range(1, 4); c1 = $urandom_range(1, 4);
                r2 = c1;                   c2 = $urandom_range(1, 4);
            end
            bad = hdr_bad(r1, c1, r2, c2);
            send_hdr(r1, c1, r2, c2, 1);
            check($sformatf("rnd%0d_err", it), load_err, bad);
            if (bad) begin
                beat(1'b0, NIB_W'($urandom), 1);
                check($sformatf("rnd%0d_err_hold", it), load_err, 1);
            end else if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(1, r1 * c1);
                for (int i = 0; i < k; i++) send_elem(ELEM_W'($urandom), 1);
                if ($urandom_range(0, 1) == 1) beat(1'b0, NIB_W'($urandom), 0);
                check($sformatf("rnd%0d_abort_nodone", it), load_done, 0);
            end else begin
                set_model(r1, c1, r2, c2);
                send_model(1);
                check($sformatf("rnd%0d_done", it), load_done, 1);
                check($sformatf("rnd%0d_dims", it), dims,
                      {NIB_W'(r1), NIB_W'(c1), NIB_W'(r2), NIB_W'(c2)});
                for (int j = 0; j < 12; j++) begin
                    bit s;
                    int rr, cc;
                    s  = 1'($urandom);
                    rr = $urandom_range(0, 5);
                    cc = $urandom_range(0, 5);
                    rd_check($sformatf("rnd%0d_rd_s%0d_%0d_%0d", it, s, rr, cc), s, rr, cc, exp_rd(s, rr, cc));
                end
                ack_pulse();
                check($sformatf("rnd%0d_ack", it), load_done, 0);
                beat(1'b0, NIB_W'($urandom), 0);
                check($sformatf("rnd%0d_idle_drop", it), load_err, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
